// File: rtl/accum_adder_pkg.sv
// Shared mode encodings for the registered add/accumulate unit.
package accum_adder_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ADD = 2'b00;
  localparam mode_t MODE_ACC = 2'b01;
  localparam mode_t MODE_SAT = 2'b10;
  localparam mode_t MODE_SUB = 2'b11;

endpackage

// File: rtl/accum_adder_alu.sv
// Combinational datapath: computes the next result and the overflow bit for one op.
module accum_adder_alu
  import accum_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  mode_t            mode_i,
  output logic [WIDTH-1:0] res_o,
  output logic             ovf_o
);

  logic [WIDTH:0] sum_ab;
  logic [WIDTH:0] sum_acc;
  logic [WIDTH:0] diff_ab;

  // One extra bit keeps the carry (or the borrow, for the difference).
  assign sum_ab  = {1'b0, a_i} + {1'b0, b_i};
  assign sum_acc = {1'b0, acc_i} + {1'b0, a_i};
  assign diff_ab = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    res_o = sum_ab[WIDTH-1:0];
    ovf_o = sum_ab[WIDTH];
    case (mode_i)
      MODE_ADD: begin
        res_o = sum_ab[WIDTH-1:0];
        ovf_o = sum_ab[WIDTH];
      end
      MODE_ACC: begin
        res_o = sum_acc[WIDTH-1:0];
        ovf_o = sum_acc[WIDTH];
      end
      MODE_SAT: begin
        res_o = sum_ab[WIDTH] ? {WIDTH{1'b1}} : sum_ab[WIDTH-1:0];
        ovf_o = sum_ab[WIDTH];
      end
      MODE_SUB: begin
        res_o = diff_ab[WIDTH-1:0];
        ovf_o = diff_ab[WIDTH];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/accum_adder.sv
// Registered add/accumulate unit: 1-cycle latency, sticky overflow, wrapping op counter.
module accum_adder
  import accum_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  mode_t            mode_i,
  input  logic             op_valid_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] result_o,
  output logic             result_valid_o,
  output logic             ovf_o,
  output logic [CNT_W-1:0] op_count_o
);

  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  accum_adder_alu #(.WIDTH(WIDTH)) u_alu (
    .acc_i  (result_q),
    .a_i    (a_i),
    .b_i    (b_i),
    .mode_i (mode_i),
    .res_o  (alu_res),
    .ovf_o  (alu_ovf)
  );

  // An op is accepted on any edge where op_valid_i=1 and clear_i=0; there is no
  // backpressure. result_valid_o pulses for exactly the cycle after acceptance.
  always_comb begin
    result_d = result_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      result_d = '0;
      ovf_d    = 1'b0;
      cnt_d    = '0;
    end else if (op_valid_i) begin
      result_d = alu_res;
      valid_d  = 1'b1;
      ovf_d    = ovf_q | alu_ovf;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign ovf_o          = ovf_q;
  assign op_count_o     = cnt_q;

endmodule
